// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite arbiter types: bus widths, response codes and arbiter FSM states.
// Imported by axi_lite_rr_arbiter and axi_lite_arbiter.
package axi_lite_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_RESP = 3'd4
  } arb_state_t;

endpackage

// File: rtl/axi_lite_rr_arbiter.sv
// Two-way grant selector, combinational: one-hot gnt from pending requests, zero when not enabled.
// On a tie the requester that was not granted last wins; last_grant=1 therefore favours requester 0.
module axi_lite_rr_arbiter
  import axi_lite_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (enable) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/axi_lite_arbiter.sv
// Two-requester AXI4-Lite arbiter, one whole transaction in flight; grant registered 1 cycle after request.
// Non-granted requester is held off (ready/valid 0); ARB_FIXED_PRIO_EN makes requester 0 win every tie.
module axi_lite_arbiter
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W = ADDR_WIDTH,
  parameter int DATA_W = DATA_WIDTH
) (
  input  logic                aclk,
  input  logic                areset_n,

  input  logic [ADDR_W-1:0]   s0_awaddr,
  input  logic                s0_awvalid,
  output logic                s0_awready,
  input  logic [DATA_W-1:0]   s0_wdata,
  input  logic [DATA_W/8-1:0] s0_wstrb,
  input  logic                s0_wvalid,
  output logic                s0_wready,
  output resp_t               s0_bresp,
  output logic                s0_bvalid,
  input  logic                s0_bready,
  input  logic [ADDR_W-1:0]   s0_araddr,
  input  logic                s0_arvalid,
  output logic                s0_arready,
  output logic [DATA_W-1:0]   s0_rdata,
  output resp_t               s0_rresp,
  output logic                s0_rvalid,
  input  logic                s0_rready,

  input  logic [ADDR_W-1:0]   s1_awaddr,
  input  logic                s1_awvalid,
  output logic                s1_awready,
  input  logic [DATA_W-1:0]   s1_wdata,
  input  logic [DATA_W/8-1:0] s1_wstrb,
  input  logic                s1_wvalid,
  output logic                s1_wready,
  output resp_t               s1_bresp,
  output logic                s1_bvalid,
  input  logic                s1_bready,
  input  logic [ADDR_W-1:0]   s1_araddr,
  input  logic                s1_arvalid,
  output logic                s1_arready,
  output logic [DATA_W-1:0]   s1_rdata,
  output resp_t               s1_rresp,
  output logic                s1_rvalid,
  input  logic                s1_rready,

  output logic [ADDR_W-1:0]   m_awaddr,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  resp_t               m_bresp,
  input  logic                m_bvalid,
  output logic                m_bready,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic                m_arvalid,
  input  logic                m_arready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  resp_t               m_rresp,
  input  logic                m_rvalid,
  output logic                m_rready,

  output logic [1:0]          grant,
  output logic                busy
);

  arb_state_t state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       aw_done_q, aw_done_d;
  logic       w_done_q, w_done_d;
  logic       last_grant;
  logic [1:0] req;
  logic [1:0] gnt;
  logic       sel;
  logic       g_awvalid, g_wvalid, g_bready, g_arvalid, g_rready;
  logic       aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic       aw_rdy, w_rdy, b_vld, ar_rdy, r_vld;

  assign req = {s1_awvalid | s1_arvalid, s0_awvalid | s0_arvalid};
  assign sel = grant_q[1];

  axi_lite_rr_arbiter u_rr (
    .req        (req),
    .last_grant (last_grant),
    .enable     (state_q == IDLE),
    .gnt        (gnt)
  );

`ifdef ARB_FIXED_PRIO_EN
  assign last_grant = 1'b1;
`else
  logic last_grant_q, last_grant_d;

  // Owner index is remembered only when its transaction completes.
  assign last_grant_d = (b_hs || r_hs) ? sel : last_grant_q;

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  assign last_grant = last_grant_q;
`endif

  assign g_awvalid = sel ? s1_awvalid : s0_awvalid;
  assign g_wvalid  = sel ? s1_wvalid  : s0_wvalid;
  assign g_bready  = sel ? s1_bready  : s0_bready;
  assign g_arvalid = sel ? s1_arvalid : s0_arvalid;
  assign g_rready  = sel ? s1_rready  : s0_rready;

  assign m_awaddr = sel ? s1_awaddr : s0_awaddr;
  assign m_wdata  = sel ? s1_wdata  : s0_wdata;
  assign m_wstrb  = sel ? s1_wstrb  : s0_wstrb;
  assign m_araddr = sel ? s1_araddr : s0_araddr;

  always_comb begin
    m_awvalid = 1'b0;
    m_wvalid  = 1'b0;
    m_bready  = 1'b0;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    unique case (state_q)
      WR_ADDR: begin
        m_awvalid = g_awvalid && !aw_done_q;
        m_wvalid  = g_wvalid  && !w_done_q;
      end
      WR_RESP: m_bready  = g_bready;
      RD_ADDR: m_arvalid = g_arvalid;
      RD_RESP: m_rready  = g_rready;
      default: ;
    endcase
  end

  assign aw_hs = m_awvalid && m_awready;
  assign w_hs  = m_wvalid  && m_wready;
  assign b_hs  = m_bvalid  && m_bready;
  assign ar_hs = m_arvalid && m_arready;
  assign r_hs  = m_rvalid  && m_rready;

  // Upstream handshake signals exist only for the owner and only in the matching phase.
  assign aw_rdy = (state_q == WR_ADDR) && !aw_done_q && m_awready;
  assign w_rdy  = (state_q == WR_ADDR) && !w_done_q  && m_wready;
  assign b_vld  = (state_q == WR_RESP) && m_bvalid;
  assign ar_rdy = (state_q == RD_ADDR) && m_arready;
  assign r_vld  = (state_q == RD_RESP) && m_rvalid;

  assign s0_awready = aw_rdy && grant_q[0];
  assign s1_awready = aw_rdy && grant_q[1];
  assign s0_wready  = w_rdy  && grant_q[0];
  assign s1_wready  = w_rdy  && grant_q[1];
  assign s0_bvalid  = b_vld  && grant_q[0];
  assign s1_bvalid  = b_vld  && grant_q[1];
  assign s0_arready = ar_rdy && grant_q[0];
  assign s1_arready = ar_rdy && grant_q[1];
  assign s0_rvalid  = r_vld  && grant_q[0];
  assign s1_rvalid  = r_vld  && grant_q[1];

  assign s0_bresp = m_bresp;
  assign s1_bresp = m_bresp;
  assign s0_rdata = m_rdata;
  assign s1_rdata = m_rdata;
  assign s0_rresp = m_rresp;
  assign s1_rresp = m_rresp;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    unique case (state_q)
      IDLE: begin
        if (gnt != 2'b00) begin
          grant_d = gnt;
          // A requester holding both AW and AR is served write-first.
          state_d = (gnt[1] ? s1_awvalid : s0_awvalid) ? WR_ADDR : RD_ADDR;
        end
      end
      WR_ADDR: begin
        aw_done_d = aw_done_q || aw_hs;
        w_done_d  = w_done_q  || w_hs;
        if (aw_done_d && w_done_d) begin
          state_d   = WR_RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      WR_RESP: begin
        if (b_hs) begin
          state_d = IDLE;
          grant_d = 2'b00;
        end
      end
      RD_ADDR: begin
        if (ar_hs) begin
          state_d = RD_RESP;
        end
      end
      RD_RESP: begin
        if (r_hs) begin
          state_d = IDLE;
          grant_d = 2'b00;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_q   <= IDLE;
      grant_q   <= 2'b00;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed bench for axi_lite_arbiter: inputs change 1 ns after the rising edge, outputs are sampled on the falling edge.
module tb_axi_lite_arbiter;
  import axi_lite_pkg::*;

  logic        aclk = 1'b0;
  logic        areset_n;

  logic [31:0] s0_awaddr, s0_wdata, s0_araddr, s0_rdata;
  logic [3:0]  s0_wstrb;
  logic        s0_awvalid, s0_awready, s0_wvalid, s0_wready, s0_bvalid, s0_bready;
  logic        s0_arvalid, s0_arready, s0_rvalid, s0_rready;
  resp_t       s0_bresp, s0_rresp;

  logic [31:0] s1_awaddr, s1_wdata, s1_araddr, s1_rdata;
  logic [3:0]  s1_wstrb;
  logic        s1_awvalid, s1_awready, s1_wvalid, s1_wready, s1_bvalid, s1_bready;
  logic        s1_arvalid, s1_arready, s1_rvalid, s1_rready;
  resp_t       s1_bresp, s1_rresp;

  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [3:0]  m_wstrb;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  resp_t       m_bresp, m_rresp;

  logic [1:0]  grant;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int aw_hs_cnt = 0, w_hs_cnt = 0, b_hs_cnt = 0, bready_cyc = 0;

  always #5 aclk = ~aclk;

  axi_lite_arbiter dut (
    .aclk(aclk), .areset_n(areset_n),
    .s0_awaddr(s0_awaddr), .s0_awvalid(s0_awvalid), .s0_awready(s0_awready),
    .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb), .s0_wvalid(s0_wvalid), .s0_wready(s0_wready),
    .s0_bresp(s0_bresp), .s0_bvalid(s0_bvalid), .s0_bready(s0_bready),
    .s0_araddr(s0_araddr), .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
    .s0_rdata(s0_rdata), .s0_rresp(s0_rresp), .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
    .s1_awaddr(s1_awaddr), .s1_awvalid(s1_awvalid), .s1_awready(s1_awready),
    .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb), .s1_wvalid(s1_wvalid), .s1_wready(s1_wready),
    .s1_bresp(s1_bresp), .s1_bvalid(s1_bvalid), .s1_bready(s1_bready),
    .s1_araddr(s1_araddr), .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
    .s1_rdata(s1_rdata), .s1_rresp(s1_rresp), .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .grant(grant), .busy(busy)
  );

  always @(posedge aclk) begin
    if (m_awvalid && m_awready) aw_hs_cnt <= aw_hs_cnt + 1;
    if (m_wvalid && m_wready)   w_hs_cnt  <= w_hs_cnt + 1;
    if (m_bvalid && m_bready)   b_hs_cnt  <= b_hs_cnt + 1;
    if (m_bready)               bready_cyc <= bready_cyc + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge aclk);
    #1;
  endtask

  task automatic mid();
    @(negedge aclk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int aw0, w0, b0, br0, k;
    logic [1:0] exp_g;

    areset_n = 1'b0;
    s0_awaddr = '0; s0_wdata = '0; s0_wstrb = '0; s0_araddr = '0;
    s0_awvalid = 1'b1; s0_wvalid = 1'b1; s0_bready = 1'b0; s0_arvalid = 1'b1; s0_rready = 1'b0;
    s1_awaddr = '0; s1_wdata = '0; s1_wstrb = '0; s1_araddr = '0;
    s1_awvalid = 1'b0; s1_wvalid = 1'b0; s1_bready = 1'b0; s1_arvalid = 1'b1; s1_rready = 1'b0;
    m_awready = 1'b1; m_wready = 1'b1; m_arready = 1'b1;
    m_bvalid = 1'b1; m_rvalid = 1'b1; m_bresp = OKAY; m_rresp = OKAY; m_rdata = '0;

    // Reset state with downstream/upstream activity that must not leak through.
    repeat (3) @(posedge aclk);
    mid();
    chk("reset_grant", grant, 2'b00);
    chk("reset_busy", busy, 1'b0);
    chk("reset_m_valids", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}, 5'b0);
    chk("reset_s_handshakes", {s0_awready, s0_wready, s0_arready, s0_bvalid, s0_rvalid,
                               s1_awready, s1_wready, s1_arready, s1_bvalid, s1_rvalid}, 10'b0);
    s0_awvalid = 1'b0; s0_wvalid = 1'b0; s0_arvalid = 1'b0; s1_arvalid = 1'b0;
    m_bvalid = 1'b0; m_rvalid = 1'b0;
    nxt();
    areset_n = 1'b1;

    // s0 single write, OKAY response.
    nxt();
    s0_awaddr = 32'h10; s0_wdata = 32'hA5A5A5A5; s0_wstrb = 4'hF;
    s0_awvalid = 1'b1; s0_wvalid = 1'b1; s0_bready = 1'b1;
    mid();
    chk("t1_idle_grant", grant, 2'b00);
    chk("t1_idle_m_awvalid", m_awvalid, 1'b0);
    chk("t1_idle_s0_awready", s0_awready, 1'b0);
    nxt();
    mid();
    chk("t1_grant", grant, 2'b01);
    chk("t1_busy", busy, 1'b1);
    chk("t1_m_awvalid", m_awvalid, 1'b1);
    chk("t1_m_awaddr", m_awaddr, 32'h10);
    chk("t1_m_wvalid", m_wvalid, 1'b1);
    chk("t1_m_wdata", m_wdata, 32'hA5A5A5A5);
    chk("t1_m_wstrb", m_wstrb, 4'hF);
    chk("t1_awready_route", {s1_awready, s0_awready}, 2'b01);
    chk("t1_wready_route", {s1_wready, s0_wready}, 2'b01);
    nxt();
    s0_awvalid = 1'b0; s0_wvalid = 1'b0;
    m_bvalid = 1'b1; m_bresp = OKAY;
    mid();
    chk("t1_m_valids_in_resp", {m_awvalid, m_wvalid}, 2'b00);
    chk("t1_bvalid_route", {s1_bvalid, s0_bvalid}, 2'b01);
    chk("t1_bresp", s0_bresp, OKAY);
    chk("t1_m_bready", m_bready, 1'b1);
    nxt();
    m_bvalid = 1'b0; s0_bready = 1'b0;
    mid();
    chk("t1_grant_end", grant, 2'b00);
    chk("t1_busy_end", busy, 1'b0);

    // s1 write, W accepted 3 cycles before AW, SLVERR response.
    aw0 = aw_hs_cnt; w0 = w_hs_cnt; b0 = b_hs_cnt; br0 = bready_cyc;
    nxt();
    s1_awaddr = 32'h30; s1_wdata = 32'h12345678; s1_wstrb = 4'h3;
    s1_awvalid = 1'b1; s1_wvalid = 1'b1; s1_bready = 1'b1;
    m_awready = 1'b0; m_wready = 1'b1;
    mid();
    nxt();
    mid();
    chk("t2_grant", grant, 2'b10);
    chk("t2_wready_route", {s1_wready, s0_wready}, 2'b10);
    chk("t2_m_wstrb", m_wstrb, 4'h3);
    nxt();
    s1_wvalid = 1'b0;
    mid();
    chk("t2_w_done_m_wvalid", m_wvalid, 1'b0);
    chk("t2_aw_pending", m_awvalid, 1'b1);
    nxt();
    mid();
    chk("t2_still_wr_addr", {m_awvalid, m_bready}, 2'b10);
    nxt();
    m_awready = 1'b1;
    mid();
    chk("t2_awready_route", {s1_awready, s0_awready}, 2'b10);
    chk("t2_s1_wready_after_w", s1_wready, 1'b0);
    chk("t2_m_awaddr", m_awaddr, 32'h30);
    nxt();
    s1_awvalid = 1'b0;
    m_bvalid = 1'b1; m_bresp = SLVERR;
    mid();
    chk("t2_bvalid_route", {s1_bvalid, s0_bvalid}, 2'b10);
    chk("t2_bresp_slverr", s1_bresp, SLVERR);
    nxt();
    m_bvalid = 1'b0; m_bresp = OKAY; s1_bready = 1'b0;
    mid();
    chk("t2_grant_end", grant, 2'b00);
    chk("t2_aw_hs_once", aw_hs_cnt - aw0, 1);
    chk("t2_w_hs_once", w_hs_cnt - w0, 1);
    chk("t2_b_hs_once", b_hs_cnt - b0, 1);
    chk("t2_wr_resp_once", bready_cyc - br0, 1);

    // s1 AW and AR together: write completes before the read is forwarded.
    nxt();
    m_awready = 1'b1; m_wready = 1'b1; m_arready = 1'b1;
    s1_awaddr = 32'h20; s1_araddr = 32'h24; s1_wdata = 32'hDEADBEEF; s1_wstrb = 4'hF;
    s1_awvalid = 1'b1; s1_wvalid = 1'b1; s1_arvalid = 1'b1; s1_bready = 1'b1; s1_rready = 1'b1;
    mid();
    nxt();
    mid();
    chk("t3_grant", grant, 2'b10);
    chk("t3_write_first_aw", m_awvalid, 1'b1);
    chk("t3_m_awaddr", m_awaddr, 32'h20);
    chk("t3_no_arvalid_wr", {m_arvalid, s1_arready}, 2'b00);
    nxt();
    s1_awvalid = 1'b0; s1_wvalid = 1'b0;
    m_bvalid = 1'b1;
    mid();
    chk("t3_b_before_ar", {s1_bvalid, m_arvalid}, 2'b10);
    nxt();
    m_bvalid = 1'b0; s1_bready = 1'b0;
    mid();
    chk("t3_idle_gap", {grant, m_arvalid}, 3'b000);
    nxt();
    mid();
    chk("t3_rd_grant", grant, 2'b10);
    chk("t3_m_arvalid", m_arvalid, 1'b1);
    chk("t3_m_araddr", m_araddr, 32'h24);
    chk("t3_arready_route", {s1_arready, s0_arready}, 2'b10);
    nxt();
    s1_arvalid = 1'b0;
    m_rvalid = 1'b1; m_rdata = 32'hCAFEF00D; m_rresp = OKAY;
    mid();
    chk("t3_rvalid_route", {s1_rvalid, s0_rvalid}, 2'b10);
    chk("t3_rdata", s1_rdata, 32'hCAFEF00D);
    nxt();
    m_rvalid = 1'b0;
    mid();
    chk("t3_grant_end", grant, 2'b00);

    // Reset during RD_RESP with rvalid withheld, then a normal s1 read.
    nxt();
    s0_araddr = 32'h40; s0_arvalid = 1'b1; s0_rready = 1'b1;
    mid();
    nxt();
    mid();
    chk("t4_grant", grant, 2'b01);
    chk("t4_m_araddr", m_araddr, 32'h40);
    nxt();
    s0_arvalid = 1'b0;
    mid();
    chk("t4_rd_resp_wait", {busy, m_rready, s0_rvalid}, 3'b110);
    #2;
    areset_n = 1'b0;
    #1;
    chk("t4_async_grant", grant, 2'b00);
    chk("t4_async_busy", busy, 1'b0);
    chk("t4_async_valids", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready,
                            s0_arready, s0_rvalid, s1_arready, s1_rvalid}, 9'b0);
    nxt();
    areset_n = 1'b1;
    s1_araddr = 32'h50; s1_arvalid = 1'b1; s1_rready = 1'b1;
    mid();
    chk("t4_post_reset_idle", grant, 2'b00);
    nxt();
    mid();
    chk("t4_s1_grant", grant, 2'b10);
    chk("t4_s1_m_araddr", m_araddr, 32'h50);
    nxt();
    s1_arvalid = 1'b0;
    m_rvalid = 1'b1; m_rdata = 32'h0BADBEEF; m_rresp = EXOKAY;
    mid();
    chk("t4_s1_rvalid", {s1_rvalid, s0_rvalid}, 2'b10);
    chk("t4_s1_rdata", s1_rdata, 32'h0BADBEEF);
    chk("t4_s1_rresp", s1_rresp, EXOKAY);
    nxt();
    m_rvalid = 1'b0; m_rresp = OKAY;
    mid();
    chk("t4_end", {grant, busy}, 3'b000);

    // Both requesters read continuously from reset: alternating grants (fixed priority: s0 every time).
    nxt();
    areset_n = 1'b0;
    nxt();
    areset_n = 1'b1;
    nxt();
    m_arready = 1'b1; m_rvalid = 1'b1; m_rdata = 32'h5555AAAA;
    s0_araddr = 32'h100; s1_araddr = 32'h200;
    s0_rready = 1'b1; s1_rready = 1'b1;
    s0_arvalid = 1'b1; s1_arvalid = 1'b1;
    mid();
    for (int i = 0; i < 8; i++) begin
`ifdef ARB_FIXED_PRIO_EN
      exp_g = 2'b01;
`else
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
`endif
      k = 0;
      while (grant == 2'b00 && k < 10) begin
        nxt();
        mid();
        k++;
      end
      chk($sformatf("rr_grant_%0d", i), grant, exp_g);
      chk($sformatf("rr_m_araddr_%0d", i), m_araddr, exp_g[1] ? 32'h200 : 32'h100);
      k = 0;
      while (grant != 2'b00 && k < 10) begin
        nxt();
        mid();
        k++;
      end
      chk($sformatf("rr_release_%0d", i), grant, 2'b00);
    end
    s0_arvalid = 1'b0; s1_arvalid = 1'b0;
    nxt();
    m_rvalid = 1'b0;
    mid();
    chk("rr_final_idle", {grant, busy, m_arvalid}, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_lite_arbiter.md
AXI_LITE_ARBITER -- requirements
Module: axi_lite_arbiter

Interface
REQ-001 Parameter ADDR_W, default axi_lite_pkg::ADDR_WIDTH (32), address width on all AW/AR channels.
REQ-002 Parameter DATA_W, default axi_lite_pkg::DATA_WIDTH (32), data width on W/R channels; WSTRB width is DATA_W/8.
REQ-003 aclk  input  1  single clock; every register is clocked on its rising edge.
REQ-004 areset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 s0_*  slave-side bundle  full AXI4-Lite (AW, W, B, AR, R; PROT omitted)  upstream requester 0.
REQ-006 s1_*  slave-side bundle  identical to s0_*  upstream requester 1.
REQ-007 m_*  master-side bundle  full AXI4-Lite  single shared downstream slave.
REQ-008 grant  output  2  one-hot owner of the downstream port; 2'b00 when idle.
REQ-009 busy  output  1  high whenever state is not IDLE.

Function
REQ-010 The arbiter SHALL grant whole transactions (write = AW+W+B, read = AR+R), with at most one transaction outstanding downstream.
REQ-011 The FSM SHALL have exactly the states IDLE, WR_ADDR, WR_RESP, RD_ADDR and RD_RESP.
REQ-012 A requester is pending when its awvalid or arvalid is high; in IDLE with at least one pending requester, the grant and next state SHALL be registered on the next edge.
REQ-013 If the granted requester has both awvalid and arvalid high, the write SHALL be served first.
REQ-014 In WR_ADDR, the granted AW and W channels SHALL be muxed combinationally to m_*, with independent aw_done/w_done flags; the FSM SHALL move to WR_RESP on the edge after both handshakes have completed, in either order or in the same cycle.
REQ-015 In WR_RESP, m_b* SHALL be routed to the granted requester; on bvalid&&bready the FSM SHALL return to IDLE.
REQ-016 In RD_ADDR, AR SHALL be forwarded; on its handshake the FSM SHALL move to RD_RESP; on the rvalid&&rready handshake it SHALL return to IDLE.
REQ-017 The non-granted requester SHALL see awready, wready, arready, bvalid and rvalid all 0; m_* valids SHALL be 0 in IDLE.
REQ-018 Minimum latency from upstream valid to downstream valid is 1 cycle; IDLE SHALL last at least 1 cycle between transactions.
REQ-019 Round-robin: the last_grant register SHALL update on transaction completion; when both requesters are pending, the one not last granted SHALL win.
REQ-020 Payloads (addr, data, strb, resp) SHALL pass through unmodified; BRESP/RRESP values are never generated internally.

Reset
REQ-021 On areset_n low: state=IDLE, grant=0, busy=0, last_grant=1 (so requester 0 wins the first tie), aw_done=w_done=0, and all valid/ready outputs 0.
REQ-022 Reset asserted mid-transaction SHALL abort the transaction silently with no response returned; after release the arbiter SHALL resume from IDLE.

Configuration
REQ-023 Macro ARB_FIXED_PRIO_EN: when defined, requester 0 SHALL always win ties and last_grant SHALL be removed; when undefined, round-robin per REQ-019 applies.

Structure
REQ-024 axi_lite_pkg SHALL hold ADDR_WIDTH, DATA_WIDTH, the resp_t typedef (OKAY, EXOKAY, SLVERR, DECERR) and the arb_state_t enum.
REQ-025 Grant selection SHALL live in sub-module axi_lite_rr_arbiter (inputs: req[1:0], last_grant, enable; output: one-hot gnt).

Verification
REQ-026 s0 write addr 0x10, data 0xA5A5A5A5 -> m_awaddr 0x10 one cycle later, s0 gets BRESP OKAY, grant=01, then 00.
REQ-027 s0 and s1 both assert arvalid in the same cycle after reset -> s0 is served first, then s1; order repeats alternately over 4 rounds (with ARB_FIXED_PRIO_EN defined, s0 always wins).
REQ-028 Downstream delivers W handshake 3 cycles before AW -> single B forwarded; state passes WR_ADDR->WR_RESP exactly once.
REQ-029 s1 issues AW and AR together (addr 0x20/0x24) -> write completes before m_arvalid rises.
REQ-030 areset_n pulled low during RD_RESP while rvalid is withheld -> all outputs go 0 asynchronously; next s1 read after release completes normally.
REQ-031 Downstream returns BRESP SLVERR -> granted requester receives SLVERR unchanged; the other requester sees bvalid=0.
